// File: rtl/acc_collector_if.sv
// Partial-sum input and PPU drain bus of acc_collector.
// The slave side is the collector; the master side is the PE array / PPU environment.
interface acc_collector_if #(
   parameter int unsigned PSUM_W = 20,
   parameter int unsigned ACC_W  = 24
) ();
   localparam int unsigned LANES = 16;

   logic                    i_psum_valid;
   logic                    o_psum_ready;
   logic [PSUM_W*LANES-1:0] i_psum_data;
   logic                    i_flush;
   logic                    o_ppu_start;
   logic [ACC_W*LANES-1:0]  o_acc_data;
   logic                    o_acc_valid;
   logic                    o_busy;
   logic                    o_sat;

   modport master (
      output i_psum_valid, i_psum_data, i_flush,
      input  o_psum_ready, o_ppu_start, o_acc_data, o_acc_valid, o_busy, o_sat
   );

   modport slave (
      input  i_psum_valid, i_psum_data, i_flush,
      output o_psum_ready, o_ppu_start, o_acc_data, o_acc_valid, o_busy, o_sat
   );
endinterface

// File: rtl/acc_collector.sv
// Accumulates K_TILES passes of 16-lane partial-sum rows into a saturating 16x16 tile,
// then pulses the PPU start and drains one row per cycle.
module acc_collector #(
   parameter int unsigned PSUM_W  = 20,
   parameter int unsigned ACC_W   = 24,
   parameter int unsigned K_TILES = 4
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   acc_collector_if.slave  bus
);
   localparam int unsigned LANES = 16;
   localparam int unsigned ROWS  = 16;
   localparam int unsigned ROW_W = 4;
   localparam int unsigned K_W   = (K_TILES > 1) ? $clog2(K_TILES) : 1;
   localparam int unsigned SUM_W = ACC_W + 1;
   localparam int unsigned DW    = ACC_W * LANES;

   typedef enum logic [1:0] {S_ACCUM, S_START, S_DRAIN} state_t;

   state_t                  r_state, w_state_nxt;
   logic [ROW_W-1:0]        r_row_cnt, w_row_nxt;
   logic [ROW_W-1:0]        r_d_cnt, w_d_nxt;
   logic [K_W-1:0]          r_k_cnt, w_k_nxt;
   logic signed [ACC_W-1:0] r_acc [ROWS][LANES];
   logic signed [ACC_W-1:0] w_psum_sext [LANES];
   logic signed [SUM_W-1:0] w_sum [LANES];
   logic signed [ACC_W-1:0] w_lane_nxt [LANES];
   logic                    w_accept;
   logic                    w_sat_hit;

   logic                    r_psum_ready, w_psum_ready_nxt;
   logic                    r_ppu_start,  w_ppu_start_nxt;
   logic                    r_acc_valid,  w_acc_valid_nxt;
   logic                    r_busy,       w_busy_nxt;
   logic                    r_sat;
   logic [DW-1:0]           r_acc_data,   w_acc_data_nxt;

   // A beat coinciding with a flush is dropped.
   assign w_accept = (r_state == S_ACCUM) && bus.i_psum_valid && !bus.i_flush;

   // First pass overwrites; later passes add at ACC_W+1 bits and clamp on overflow.
   always_comb begin
      w_sat_hit = 1'b0;
      for (int j = 0; j < LANES; j++) begin
         w_psum_sext[j] = ACC_W'(signed'(bus.i_psum_data[j*PSUM_W +: PSUM_W]));
         w_sum[j]       = SUM_W'(r_acc[r_row_cnt][j]) + SUM_W'(w_psum_sext[j]);
         w_lane_nxt[j]  = w_sum[j][ACC_W-1:0];
         if (r_k_cnt == '0) begin
            w_lane_nxt[j] = w_psum_sext[j];
         end else if (w_sum[j][SUM_W-1] != w_sum[j][SUM_W-2]) begin
            w_sat_hit     = 1'b1;
            w_lane_nxt[j] = w_sum[j][SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                              : {1'b0, {(ACC_W-1){1'b1}}};
         end
      end
   end

   // State and counter register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_ACCUM;
         r_row_cnt <= '0;
         r_k_cnt   <= '0;
         r_d_cnt   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_row_cnt <= w_row_nxt;
         r_k_cnt   <= w_k_nxt;
         r_d_cnt   <= w_d_nxt;
      end
   end

   // Next-state and counter logic; flush overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row_cnt;
      w_k_nxt     = r_k_cnt;
      w_d_nxt     = r_d_cnt;
      case (r_state)
         S_ACCUM: begin
            if (w_accept) begin
               if (r_row_cnt == ROW_W'(ROWS - 1)) begin
                  w_row_nxt = '0;
                  if (r_k_cnt == K_W'(K_TILES - 1)) begin
                     w_k_nxt     = '0;
                     w_state_nxt = S_START;
                  end else begin
                     w_k_nxt = r_k_cnt + K_W'(1);
                  end
               end else begin
                  w_row_nxt = r_row_cnt + ROW_W'(1);
               end
            end
         end
         S_START: begin
            w_state_nxt = S_DRAIN;
            w_d_nxt     = '0;
         end
         S_DRAIN: begin
            if (r_d_cnt == ROW_W'(ROWS - 1)) begin
               w_state_nxt = S_ACCUM;
               w_d_nxt     = '0;
            end else begin
               w_d_nxt = r_d_cnt + ROW_W'(1);
            end
         end
         default: w_state_nxt = S_ACCUM;
      endcase
      if (bus.i_flush) begin
         w_state_nxt = S_ACCUM;
         w_row_nxt   = '0;
         w_k_nxt     = '0;
         w_d_nxt     = '0;
      end
   end

   // Output values for the coming cycle, decoded from the next state.
   always_comb begin
      w_psum_ready_nxt = (w_state_nxt == S_ACCUM);
      w_ppu_start_nxt  = (w_state_nxt == S_START);
      w_acc_valid_nxt  = (w_state_nxt == S_DRAIN);
      w_busy_nxt       = (w_state_nxt == S_START) || (w_state_nxt == S_DRAIN);
      w_acc_data_nxt   = '0;
      if (w_state_nxt == S_DRAIN) begin
         for (int j = 0; j < LANES; j++) begin
            w_acc_data_nxt[j*ACC_W +: ACC_W] = r_acc[w_d_nxt][j];
         end
      end
   end

   // Output registers; saturation flag is sticky until reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_psum_ready <= 1'b1;
         r_ppu_start  <= 1'b0;
         r_acc_valid  <= 1'b0;
         r_busy       <= 1'b0;
         r_sat        <= 1'b0;
         r_acc_data   <= '0;
      end else begin
         r_psum_ready <= w_psum_ready_nxt;
         r_ppu_start  <= w_ppu_start_nxt;
         r_acc_valid  <= w_acc_valid_nxt;
         r_busy       <= w_busy_nxt;
         r_sat        <= r_sat | (w_accept & w_sat_hit);
         r_acc_data   <= w_acc_data_nxt;
      end
   end

   // Accumulator tile, written only on an accepted beat.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int j = 0; j < LANES; j++) begin
               r_acc[r][j] <= '0;
            end
         end
      end else if (w_accept) begin
         for (int j = 0; j < LANES; j++) begin
            r_acc[r_row_cnt][j] <= w_lane_nxt[j];
         end
      end
   end

   assign bus.o_psum_ready = r_psum_ready;
   assign bus.o_ppu_start  = r_ppu_start;
   assign bus.o_acc_valid  = r_acc_valid;
   assign bus.o_busy       = r_busy;
   assign bus.o_sat        = r_sat;
   assign bus.o_acc_data   = r_acc_data;

endmodule

// File: tb/tb_acc_collector.sv
// Bench for acc_collector: a K_TILES=4 and a K_TILES=20 instance share one stimulus stream
// and are each compared every cycle against a tile-level reference model.
module tb_acc_collector;
   localparam int unsigned PSUM_W = 20;
   localparam int unsigned ACC_W  = 24;
   localparam int unsigned LANES  = 16;
   localparam int unsigned PW     = PSUM_W * LANES;
   localparam int unsigned DW     = ACC_W * LANES;
   localparam longint      AMAX   = (longint'(1) << (ACC_W - 1)) - 1;
   localparam longint      AMIN   = -(longint'(1) << (ACC_W - 1));

   logic          i_clk    = 1'b0;
   logic          i_rst_n  = 1'b0;
   logic          tb_valid = 1'b0;
   logic          tb_flush = 1'b0;
   logic [PW-1:0] tb_data  = '0;
   bit            chk_en   = 1'b0;
   int            tests_run    = 0;
   int            tests_failed = 0;

   acc_collector_if #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) if0 ();
   acc_collector_if #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) if1 ();

   assign if0.i_psum_valid = tb_valid;
   assign if0.i_psum_data  = tb_data;
   assign if0.i_flush      = tb_flush;
   assign if1.i_psum_valid = tb_valid;
   assign if1.i_psum_data  = tb_data;
   assign if1.i_flush      = tb_flush;

   acc_collector #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .K_TILES(4))  u_dut0 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if0));
   acc_collector #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .K_TILES(20)) u_dut1 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if1));

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: tile contents as plain integers plus a phase number
   // (0 = accepting, 1 = start pulse, 2..17 = draining row phase-2).
   longint macc [2][16][16];
   int     mrow [2];
   int     mk   [2];
   int     mphase [2];
   bit     msat [2];

   function automatic int kt(input int i);
      return (i == 0) ? 4 : 20;
   endfunction

   function automatic longint lane_in(input int j);
      logic signed [PSUM_W-1:0] v;
      v = tb_data[j*PSUM_W +: PSUM_W];
      return longint'(v);
   endfunction

   always @(posedge i_clk or negedge i_rst_n) begin
      longint s;
      if (!i_rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mphase[i] <= 0;
            mrow[i]   <= 0;
            mk[i]     <= 0;
            msat[i]   <= 1'b0;
            for (int r = 0; r < 16; r++)
               for (int j = 0; j < 16; j++) macc[i][r][j] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (tb_flush) begin
               mphase[i] <= 0;
               mrow[i]   <= 0;
               mk[i]     <= 0;
            end else if (mphase[i] == 0) begin
               if (tb_valid) begin
                  for (int j = 0; j < 16; j++) begin
                     s = lane_in(j);
                     if (mk[i] != 0) begin
                        s = macc[i][mrow[i]][j] + s;
                        if (s > AMAX) begin s = AMAX; msat[i] <= 1'b1; end
                        else if (s < AMIN) begin s = AMIN; msat[i] <= 1'b1; end
                     end
                     macc[i][mrow[i]][j] <= s;
                  end
                  if (mrow[i] == 15) begin
                     mrow[i] <= 0;
                     if (mk[i] == kt(i) - 1) begin
                        mk[i]     <= 0;
                        mphase[i] <= 1;
                     end else begin
                        mk[i] <= mk[i] + 1;
                     end
                  end else begin
                     mrow[i] <= mrow[i] + 1;
                  end
               end
            end else begin
               mphase[i] <= (mphase[i] == 17) ? 0 : mphase[i] + 1;
            end
         end
      end
   end

   task automatic check_inst(input int i, input logic rdy, input logic st, input logic vld,
                             input logic bsy, input logic sat, input logic [DW-1:0] data);
      logic [DW-1:0] ed;
      int p;
      p  = mphase[i];
      ed = '0;
      if (p >= 2)
         for (int j = 0; j < 16; j++) ed[j*ACC_W +: ACC_W] = ACC_W'(macc[i][p-2][j]);
      chk($sformatf("dut%0d ready", i), DW'(rdy), DW'(p == 0));
      chk($sformatf("dut%0d ppu_start", i), DW'(st), DW'(p == 1));
      chk($sformatf("dut%0d acc_valid", i), DW'(vld), DW'(p >= 2));
      chk($sformatf("dut%0d busy", i), DW'(bsy), DW'(p != 0));
      chk($sformatf("dut%0d sat", i), DW'(sat), DW'(msat[i]));
      chk($sformatf("dut%0d acc_data", i), data, ed);
   endtask

   // Per-cycle comparison, mid-cycle.
   always @(negedge i_clk) begin
      if (chk_en) begin
         check_inst(0, if0.o_psum_ready, if0.o_ppu_start, if0.o_acc_valid, if0.o_busy,
                    if0.o_sat, if0.o_acc_data);
         check_inst(1, if1.o_psum_ready, if1.o_ppu_start, if1.o_acc_valid, if1.o_busy,
                    if1.o_sat, if1.o_acc_data);
      end
   end

   task automatic step();
      @(posedge i_clk);
      #2;
   endtask

   function automatic logic [PW-1:0] fill(input int v);
      logic [PW-1:0] d;
      for (int j = 0; j < 16; j++) d[j*PSUM_W +: PSUM_W] = PSUM_W'(v);
      return d;
   endfunction

   function automatic logic [PW-1:0] rand_data();
      logic [PW-1:0] d;
      for (int j = 0; j < 16; j++) d[j*PSUM_W +: PSUM_W] = PSUM_W'($urandom);
      return d;
   endfunction

   function automatic logic [DW-1:0] row_lit(input int base, input int add);
      logic [DW-1:0] d;
      for (int j = 0; j < 16; j++) d[j*ACC_W +: ACC_W] = ACC_W'(base + j + add);
      return d;
   endfunction

   function automatic logic [DW-1:0] const_row(input int v);
      logic [DW-1:0] d;
      for (int j = 0; j < 16; j++) d[j*ACC_W +: ACC_W] = ACC_W'(v);
      return d;
   endfunction

   task automatic send(input int n, input int v);
      tb_valid = 1'b1;
      tb_data  = fill(v);
      repeat (n) step();
      tb_valid = 1'b0;
   endtask

   task automatic flush_cycle();
      tb_flush = 1'b1;
      tb_valid = 1'b1;
      tb_data  = rand_data();
      step();
      tb_flush = 1'b0;
      tb_valid = 1'b0;
   endtask

   task automatic wait_start1(input int maxc);
      int n;
      n = 0;
      while (!if1.o_ppu_start && n < maxc) begin step(); n++; end
      chk("dut1 start within budget", DW'(if1.o_ppu_start), DW'(1));
   endtask

   initial begin
      int vcnt;
      int rl;
      int n;

      repeat (3) step();
      chk("reset ready", DW'(if0.o_psum_ready), DW'(1));
      chk("reset start", DW'(if0.o_ppu_start), DW'(0));
      chk("reset valid", DW'(if0.o_acc_valid), DW'(0));
      chk("reset data", if0.o_acc_data, '0);
      chk("reset busy", DW'(if0.o_busy), DW'(0));
      chk("reset sat", DW'(if0.o_sat), DW'(0));
      chk_en  = 1'b1;
      i_rst_n = 1'b1;
      step();

      // 64 beats of +1: start next cycle, 16 rows of 4.
      send(64, 1);
      chk("A start", DW'(if0.o_ppu_start), DW'(1));
      step();
      chk("A row0", if0.o_acc_data, const_row(4));
      vcnt = 1;
      repeat (20) begin step(); if (if0.o_acc_valid) vcnt++; end
      chk("A valid cycles", DW'(vcnt), DW'(16));
      chk("A sat", DW'(if0.o_sat), DW'(0));

      // Pass 0 = r*16+j, passes 1..3 = -1.
      tb_valid = 1'b1;
      for (int b = 0; b < 64; b++) begin
         for (int j = 0; j < 16; j++)
            tb_data[j*PSUM_W +: PSUM_W] = (b < 16) ? PSUM_W'((b % 16) * 16 + j) : PSUM_W'(-1);
         step();
      end
      tb_valid = 1'b0;
      chk("B start", DW'(if0.o_ppu_start), DW'(1));
      step();
      chk("B row0", if0.o_acc_data, row_lit(0, -3));
      repeat (3) step();
      chk("B row3", if0.o_acc_data, row_lit(48, -3));
      repeat (20) step();

      // Flush after 37 beats, then a clean tile of +2.
      flush_cycle();
      tb_valid = 1'b1;
      repeat (37) begin tb_data = rand_data(); step(); end
      flush_cycle();
      send(64, 2);
      chk("F start", DW'(if0.o_ppu_start), DW'(1));
      step();
      chk("F row0", if0.o_acc_data, const_row(8));
      repeat (20) step();

      // Valid held through the drain: ready low 17 cycles, next tile overwrites.
      tb_valid = 1'b1;
      tb_data  = fill(1);
      repeat (64) step();
      tb_data = fill(3);
      rl = 0;
      repeat (40) begin if (!if0.o_psum_ready) rl++; step(); end
      chk("H ready low cycles", DW'(rl), DW'(17));
      n = 0;
      while (!if0.o_ppu_start && n < 100) begin step(); n++; end
      chk("H start within budget", DW'(if0.o_ppu_start), DW'(1));
      tb_valid = 1'b0;
      step();
      chk("H row0", if0.o_acc_data, const_row(12));
      repeat (20) step();

      // Flush at drain row 5.
      send(64, 1);
      step();
      repeat (5) step();
      chk("D valid at d5", DW'(if0.o_acc_valid), DW'(1));
      tb_flush = 1'b1;
      step();
      tb_flush = 1'b0;
      chk("D valid after flush", DW'(if0.o_acc_valid), DW'(0));
      chk("D busy after flush", DW'(if0.o_busy), DW'(0));
      repeat (3) step();

      // Saturation on the K_TILES=20 instance, both signs.
      flush_cycle();
      tb_valid = 1'b1;
      tb_data  = fill(524287);
      wait_start1(600);
      tb_valid = 1'b0;
      step();
      chk("S pos row0", if1.o_acc_data, const_row(8388607));
      chk("S pos sat", DW'(if1.o_sat), DW'(1));
      repeat (20) step();
      flush_cycle();
      chk("S sat survives flush", DW'(if1.o_sat), DW'(1));
      tb_valid = 1'b1;
      tb_data  = fill(-524288);
      wait_start1(600);
      tb_valid = 1'b0;
      step();
      chk("S neg row0", if1.o_acc_data, const_row(-8388608));
      repeat (20) step();

      // Reset at drain row 8.
      flush_cycle();
      send(64, 1);
      step();
      repeat (8) step();
      chk("R valid at d8", DW'(if0.o_acc_valid), DW'(1));
      i_rst_n = 1'b0;
      #1;
      chk("R ready", DW'(if0.o_psum_ready), DW'(1));
      chk("R start", DW'(if0.o_ppu_start), DW'(0));
      chk("R valid", DW'(if0.o_acc_valid), DW'(0));
      chk("R busy", DW'(if0.o_busy), DW'(0));
      chk("R data", if0.o_acc_data, '0);
      chk("R sat dut1", DW'(if1.o_sat), DW'(0));
      repeat (2) step();
      i_rst_n = 1'b1;
      step();
      chk("R ready after release", DW'(if0.o_psum_ready), DW'(1));
      send(64, 1);
      chk("R start new tile", DW'(if0.o_ppu_start), DW'(1));
      step();
      chk("R row0 new tile", if0.o_acc_data, const_row(4));
      repeat (20) step();

      // Random traffic with sporadic flushes.
      repeat (800) begin
         tb_valid = ($urandom_range(9) < 7);
         tb_data  = rand_data();
         tb_flush = ($urandom_range(99) == 0);
         step();
      end
      tb_valid = 1'b0;
      tb_flush = 1'b0;
      repeat (30) step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
